// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM encoding
// and the data word width.
package lsu_pkg;
   localparam int WORD_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;
endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane merge for read-modify-write stores and lane extraction with
// sign/zero extension for loads; purely combinational.
// Ports: i_word (read word), i_offset (byte lane), i_size, i_wdata,
//        i_unsigned -> o_merged (store word), o_load (extended load).
module lsu_lane_merge
   import lsu_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  logic [1:0]        i_offset,
   input  logic [1:0]        i_size,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic              i_unsigned,
   output logic [WORD_W-1:0] o_merged,
   output logic [WORD_W-1:0] o_load
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_sx;

   always_comb begin
      w_byte   = i_word[{i_offset, 3'b000} +: 8];
      w_half   = i_word[{i_offset[1], 4'b0000} +: 16];
      w_sx     = 1'b0;
      o_merged = i_word;
      o_load   = '0;
      case (i_size)
         SZ_BYTE: begin
            o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
            w_sx   = ~i_unsigned & w_byte[7];
            o_load = {{24{w_sx}}, w_byte};
         end
         SZ_HALF: begin
            o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            w_sx   = ~i_unsigned & w_half[15];
            o_load = {{16{w_sx}}, w_half};
         end
         SZ_WORD: begin
            o_merged = i_wdata;
            o_load   = i_word;
         end
         default: begin
            o_merged = i_word;
            o_load   = '0;
         end
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-wide memory without byte enables;
// sub-word stores are done by read-modify-write.
// Ports: i_clk, i_reset (sync, high); request handshake i_req_*/o_req_ready;
//        response handshake o_resp_*/i_resp_ready; memory o_mem_*/i_mem_rdata.
// Option: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses errors;
//         otherwise the offending low address bits are ignored.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [31:0]       i_req_addr,
   input  logic [WORD_W-1:0] i_req_wdata,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [WORD_W-1:0] o_resp_rdata,
   output logic              o_resp_error,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [WORD_W-1:0] o_mem_wdata,
   input  logic [WORD_W-1:0] i_mem_rdata
);
   state_t            r_state;
   state_t            w_next;
   logic              r_write;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [31:0]       r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic [WORD_W-1:0] r_rd;
   logic              r_err;

   logic              w_range;
   logic              w_mis;
   logic              w_err;
   logic [1:0]        w_off;
   logic [WORD_W-1:0] w_merged;
   logic [WORD_W-1:0] w_load;

   assign w_range = |r_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_mis = ((r_size == SZ_HALF) & r_addr[0]) |
                  ((r_size == SZ_WORD) & (|r_addr[1:0]));
   assign w_off = r_addr[1:0];
`else
   assign w_mis = 1'b0;
   always_comb begin
      w_off = r_addr[1:0];
      if (r_size == SZ_HALF)
         w_off = {r_addr[1], 1'b0};
      else if (r_size == SZ_WORD)
         w_off = 2'b00;
   end
`endif

   assign w_err = (r_size == 2'd3) | w_range | w_mis;

   lsu_lane_merge u_merge (
      .i_word     (r_rd),
      .i_offset   (w_off),
      .i_size     (r_size),
      .i_wdata    (r_wdata),
      .i_unsigned (r_uns),
      .o_merged   (w_merged),
      .o_load     (w_load)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_write <= 1'b0;
         r_size  <= SZ_BYTE;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && i_req_valid) begin
            r_write <= i_req_write;
            r_size  <= i_req_size;
            r_uns   <= i_req_unsigned;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_err   <= 1'b0;
         end
         if (r_state == CHECK) begin
            r_err <= w_err;
            if (!w_err)
               r_rd <= i_mem_rdata;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      o_req_ready  = 1'b0;
      o_resp_valid = 1'b0;
      o_resp_error = 1'b0;
      o_resp_rdata = '0;
      o_mem_we     = 1'b0;
      o_mem_wdata  = '0;
      o_mem_addr   = r_addr[ADDR_W+1:2];
      unique case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            o_mem_addr  = '0;
            if (i_req_valid)
               w_next = CHECK;
         end
         CHECK: begin
            if (w_err || !r_write)
               w_next = RESP;
            else
               w_next = WRITE;
         end
         WRITE: begin
            o_mem_we    = 1'b1;
            o_mem_wdata = w_merged;
            w_next      = RESP;
         end
         RESP: begin
            o_resp_valid = 1'b1;
            o_resp_error = r_err;
            if (!r_err && !r_write)
               o_resp_rdata = w_load;
            if (i_resp_ready)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
endmodule
